// File: rtl/dm_wbuf.sv
// MEM-stage data memory with a posted FIFO write buffer in front of a slow-write RAM.
// Loads forward from the youngest matching buffered store, else read RAM combinationally.

module dm_wbuf_match #(
  parameter int AW = 10
) (
  input  logic          vld_i,
  input  logic [AW-1:0] ent_addr_i,
  input  logic [AW-1:0] ld_addr_i,
  output logic          hit_o
);
  assign hit_o = vld_i && (ent_addr_i == ld_addr_i);
endmodule

module dm_wbuf #(
  parameter int AW       = 10,
  parameter int WB_DEPTH = 4,
  parameter int WR_LAT   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    M_MEM,
  input  logic [31:0]                   ALU_resultMEM,
  input  logic [31:0]                   Mem_WDataMEM,
  output logic [31:0]                   Mem_RDataMEM,
  output logic                          mem_stall,
  output logic [$clog2(WB_DEPTH+1)-1:0] wbuf_count,
  output logic                          wbuf_empty
);
  localparam int PW   = $clog2(WB_DEPTH);
  localparam int CNTW = $clog2(WB_DEPTH+1);
  localparam int CW   = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wb_ent_t;

  typedef enum logic {IDLE, BUSY} st_e;

  wb_ent_t         fifo_q [WB_DEPTH];
  logic [31:0]     ram_q  [2**AW];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  st_e             state_q;
  logic [CW-1:0]   cnt_q;

  logic [AW-1:0]       ld_addr;
  logic                full, push, pop;
  logic [WB_DEPTH-1:0] hit;
  logic                fwd_hit;
  logic [31:0]         fwd_data;
  logic                unused_hi;

  assign ld_addr   = ALU_resultMEM[AW-1:0];
  assign unused_hi = ^ALU_resultMEM[31:AW];
  assign full      = (count_q == CNTW'(WB_DEPTH));
  assign push      = M_MEM[0] && !full;
  assign pop       = (state_q == BUSY) && (cnt_q == '0);

  assign mem_stall  = M_MEM[0] && full;
  assign wbuf_count = count_q;
  assign wbuf_empty = (count_q == '0);

  // hit[g] is in age order: g=0 is the head (oldest)
  for (genvar g = 0; g < WB_DEPTH; g++) begin : g_match
    dm_wbuf_match #(.AW(AW)) u_match (
      .vld_i      (CNTW'(g) < count_q),
      .ent_addr_i (fifo_q[head_q + PW'(g)].addr),
      .ld_addr_i  (ld_addr),
      .hit_o      (hit[g])
    );
  end

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (hit[i]) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_q[head_q + PW'(i)].data;
      end
    end
  end

  always_comb begin
    Mem_RDataMEM = '0;
    if (reset && M_MEM[1]) Mem_RDataMEM = fwd_hit ? fwd_data : ram_q[ld_addr];
  end

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + CNTW'(push) - CNTW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Drain FSM sees the count from before this edge, so fresh pushes wait one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (count_q != '0) begin
          state_q <= BUSY;
          cnt_q   <= CW'(WR_LAT-1);
        end
        BUSY: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
              else state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[tail_q] <= '{addr: ld_addr, data: Mem_WDataMEM};
  end

  // RAM keeps its contents across reset; a reset mid-drain suppresses the commit
  always_ff @(posedge clk) begin
    if (pop && reset) ram_q[fifo_q[head_q].addr] <= fifo_q[head_q].data;
  end
endmodule
